// File: rtl/ram_bit_reader.sv
// rtl/ram_bit_reader.sv - reads a burst of single bits from a 1-bit RAM and packs them MSB first into bytes
module ram_bit_reader #(
  parameter int ADDR_W = 10,
  parameter int NB_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [NB_W-1:0]   num_bytes,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic              ram_q,
  output logic [7:0]        byte_out,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = NB_W + 3;

  typedef enum logic [1:0] {IDLE, READ, STALL, DRAIN} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] cur;         // next address to issue
  logic [CNT_W-1:0]  issue_left;  // addresses still to issue in this burst
  logic [2:0]        bit_idx;     // position of the bit currently on ram_q
  logic [6:0]        shift;       // first seven bits of the byte being built
  logic              q_valid;     // ram_q carries a burst bit this cycle

  logic all_issued;
  logic last_bit;
  logic can_load;
  logic accept;
  logic issue;
  logic load;

  assign all_issued = (issue_left == '0);
  assign last_bit   = q_valid && (bit_idx == 3'd7);
  assign can_load   = !byte_valid || byte_ready;
  assign accept     = byte_valid && byte_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: a completed byte that cannot be handed over parks the FSM in STALL
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start && num_bytes != '0) state_nxt = READ;
      READ:  if (last_bit) begin
               if (!can_load)       state_nxt = STALL;
               else if (all_issued) state_nxt = DRAIN;
             end
      STALL: if (accept) state_nxt = all_issued ? DRAIN : READ;
      DRAIN: if (accept) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: when not issuing, the RAM re-reads the last issued address so ram_q stays put
  always_comb begin
    busy     = (state != IDLE);
    issue    = (state == READ) && !all_issued && !(last_bit && !can_load);
    load     = ((state == READ) && last_bit && can_load) || ((state == STALL) && accept);
    ram_addr = cur;
    if (state != IDLE && !issue) ram_addr = cur - ADDR_W'(1);
  end

  // Datapath: address pointer, bit packing, output byte register and done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      cur        <= '0;
      issue_left <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      q_valid    <= 1'b0;
      byte_out   <= '0;
      byte_valid <= 1'b0;
      done       <= 1'b0;
    end else begin
      done    <= 1'b0;
      q_valid <= issue;
      if (state == IDLE && start) begin
        cur        <= base_addr;
        issue_left <= {num_bytes, 3'b000};
        bit_idx    <= '0;
        shift      <= '0;
        if (num_bytes == '0) done <= 1'b1;
      end
      if (issue) begin
        cur        <= cur + ADDR_W'(1);
        issue_left <= issue_left - CNT_W'(1);
      end
      if (state == READ && q_valid && !last_bit) begin
        shift   <= {shift[5:0], ram_q};
        bit_idx <= bit_idx + 3'd1;
      end
      if (load) begin
        byte_out   <= {shift, ram_q};
        byte_valid <= 1'b1;
        bit_idx    <= '0;
      end else if (accept) begin
        byte_valid <= 1'b0;
      end
      if (state == DRAIN && accept) done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ram_bit_reader.sv
// tb/tb_ram_bit_reader.sv - randomized self-checking bench for ram_bit_reader
module tb_ram_bit_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [9:0] base_addr;
  logic [7:0] num_bytes;
  logic [9:0] ram_addr;
  logic       ram_q;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       byte_ready;
  logic       busy;
  logic       done;

  ram_bit_reader #(.ADDR_W(10), .NB_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_bytes(num_bytes),
    .ram_addr(ram_addr), .ram_q(ram_q), .byte_out(byte_out), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Sample RAM: 1024 x 1, registered read address
  logic mem [0:1023];
  always @(posedge clk) ram_q <= mem[ram_addr];

  int n_tests = 0;
  int n_fail  = 0;

  logic [8:0] exp_q[$];
  logic [9:0] addr_log[$];
  int         done_cnt;
  int         valid_seen;
  int         first_lat;
  int         since_start;
  logic       exp_done;
  logic       prev_hold;
  logic [7:0] prev_byte;
  logic [7:0] last_byte;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: scoreboard of accepted bytes, done timing, hold stability
  always @(negedge clk) begin
    logic [8:0] e;
    if (rst) begin
      exp_done  = 1'b0;
      prev_hold = 1'b0;
    end else begin
      check("done", done, exp_done);
      if (done) begin
        done_cnt++;
        check("busy_at_done", busy, 0);
      end
      if (busy) addr_log.push_back(ram_addr);
      if (byte_valid) valid_seen++;
      if (start && !busy) since_start = 0;
      else since_start++;
      if (byte_valid && first_lat < 0) first_lat = since_start;
      if (prev_hold) begin
        check("hold_valid", byte_valid, 1);
        check("hold_data", byte_out, prev_byte);
      end
      exp_done = start && !busy && (num_bytes == 8'd0);
      if (byte_valid && byte_ready) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h100;
        check("byte", {1'b0, byte_out}, e);
        last_byte = byte_out;
        if (exp_q.size() == 0) exp_done = 1'b1;
      end
      prev_hold = byte_valid && !byte_ready;
      prev_byte = byte_out;
    end
  end

  // Expected bytes straight from the addressing rule: bit i of byte k at base+8k+i, MSB first
  task automatic push_expected(input int base, input int n);
    logic [8:0] b;
    for (int k = 0; k < n; k++) begin
      b = '0;
      for (int i = 0; i < 8; i++) b[7-i] = mem[(base + 8*k + i) % 1024];
      exp_q.push_back(b);
    end
  endtask

  task automatic burst(input int base, input int n, input int pct, input int hold_until, input bit noise);
    int cyc;
    push_expected(base, n);
    addr_log.delete();
    done_cnt = 0; valid_seen = 0; first_lat = -1;
    @(posedge clk); #1;
    start = 1'b1; base_addr = base[9:0]; num_bytes = n[7:0];
    byte_ready = (hold_until > 0) ? 1'b0 : ($urandom_range(99) < pct);
    cyc = 0;
    while (done_cnt == 0 && cyc < 6000) begin
      @(posedge clk); #1;
      cyc++;
      start = 1'b0;
      base_addr = 10'($urandom);
      num_bytes = 8'($urandom);
      if (noise && busy && $urandom_range(7) == 0) start = 1'b1;
      byte_ready = (cyc <= hold_until) ? 1'b0 : ($urandom_range(99) < pct);
    end
    start = 1'b0;
    check("done_seen", done_cnt != 0, 1);
    repeat (3) @(posedge clk);
    #1;
    check("done_once", done_cnt, 1);
    check("queue_empty", exp_q.size(), 0);
    exp_q.delete();
    if (pct == 100 && hold_until == 0) check("valid_cycles", valid_seen, n);
    if (pct == 100 && hold_until == 0 && n > 0) check("first_latency", first_lat, 10);
  endtask

  initial begin
    int base;
    for (int i = 0; i < 1024; i++) mem[i] = 1'($urandom_range(1));
    rst = 1'b1; start = 1'b0; base_addr = '0; num_bytes = '0; byte_ready = 1'b0;
    exp_done = 1'b0; prev_hold = 1'b0; since_start = 0; first_lat = -1;
    done_cnt = 0; valid_seen = 0; last_byte = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_byte_out", byte_out, 0);
    check("rst_byte_valid", byte_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single byte 0xB2 from address 0
    {mem[0], mem[1], mem[2], mem[3], mem[4], mem[5], mem[6], mem[7]} = 8'b1011_0010;
    burst(0, 1, 100, 0, 1'b0);
    check("byte_b2", last_byte, 8'hB2);

    // Address wrap 0x3FF -> 0x000
    for (int i = 0; i < 4; i++) begin mem[1020 + i] = 1'b1; mem[i] = 1'b0; end
    burst(1020, 1, 100, 0, 1'b0);
    check("byte_f0", last_byte, 8'hF0);
    for (int i = 0; i < 8; i++) check("wrap_addr", addr_log[i], (1020 + i) % 1024);

    // Three bytes with the first byte held back long enough to force a stall
    base = $urandom_range(1023);
    burst(base, 3, 100, 21, 1'b0);
    for (int j = 16; j < 22; j++) check("stall_addr", addr_log[j], (base + 15) % 1024);

    // Empty burst
    burst($urandom_range(1023), 0, 100, 0, 1'b0);
    check("empty_no_busy", addr_log.size(), 0);
    check("empty_no_valid", valid_seen, 0);

    // Reset in the middle of the second byte of a four-byte burst
    base = $urandom_range(1023);
    push_expected(base, 4);
    done_cnt = 0;
    @(posedge clk); #1;
    start = 1'b1; base_addr = base[9:0]; num_bytes = 8'd4; byte_ready = 1'b1;
    for (int c = 1; c <= 14; c++) begin @(posedge clk); #1; start = 1'b0; end
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_ram_addr", ram_addr, 0);
    check("mid_rst_byte_out", byte_out, 0);
    check("mid_rst_valid", byte_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    repeat (12) @(posedge clk);
    #1;
    check("mid_rst_no_done", done_cnt, 0);
    burst($urandom_range(1023), 4, 100, 0, 1'b0);

    // Random bursts with backpressure and ignored start pulses
    for (int t = 0; t < 8; t++)
      burst($urandom_range(1023), $urandom_range(1, 6), $urandom_range(30, 100), 0, 1'b1);

    // Long burst re-reading wrapped addresses
    burst(1008, 140, 100, 0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
